// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the core pipeline and the hazard/CGRA sequencer.
// The core drives through master and the sequencer answers through slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_uses_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             ex_branch_taken_i;
  logic             ex_cgra_op_i;
  logic             cgra_ready_i;
  logic             cgra_done_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             idex_hold_o;
  logic             cgra_start_o;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_memread_i, ex_rd_i,
           ex_branch_taken_i, ex_cgra_op_i, cgra_ready_i, cgra_done_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           idex_hold_o, cgra_start_o, busy_o, err_o, stall_cnt_o
  );

  modport master (
    output id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_memread_i, ex_rd_i,
           ex_branch_taken_i, ex_cgra_op_i, cgra_ready_i, cgra_done_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           idex_hold_o, cgra_start_o, busy_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and CGRA issue/wait freeze.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int CGRA_TIMEOUT = 256,
  parameter int TO_W         = 9,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CGRA_TIMEOUT - 1);

  state_t          state_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;

  logic load_use;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;
  logic idex_hold;
  logic cgra_start;

  assign load_use = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                    ((bus.ex_rd_i == bus.id_rs1_i) ||
                     (bus.id_uses_rs2_i && (bus.ex_rd_i == bus.id_rs2_i)));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    idex_hold  = 1'b0;
    cgra_start = 1'b0;
    if (!rst_i) begin
      unique case (state_reg)
        ST_RUN: begin
          // Branch outranks load-use: the stalled ID instruction is squashed anyway.
          if (bus.ex_cgra_op_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
          end else if (bus.ex_branch_taken_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        ST_ISSUE: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          cgra_start = 1'b1;
        end
        ST_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_RUN;
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          if (bus.ex_cgra_op_i) begin
            state_reg  <= ST_ISSUE;
            to_cnt_reg <= '0;
          end
        end
        ST_ISSUE: begin
          if (to_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= ST_RELEASE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (bus.cgra_ready_i) state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still counts as success.
          if (bus.cgra_done_i) begin
            state_reg <= ST_RELEASE;
          end else if (to_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= ST_RELEASE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_reg;
`else
  assign bus.stall_cnt_o = '0;
`endif

  assign bus.pc_write_o   = pc_write;
  assign bus.ifid_write_o = ifid_write;
  assign bus.ifid_flush_o = ifid_flush;
  assign bus.idex_flush_o = idex_flush;
  assign bus.idex_hold_o  = idex_hold;
  assign bus.cgra_start_o = cgra_start;
  assign bus.busy_o       = !rst_i && (state_reg != ST_RUN);
  assign bus.err_o        = err_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (timeout 256 and 8) share stimulus and are
// checked every sampled cycle against a job-level model of the sequencer.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       uses2 = 1'b0, memread = 1'b0, br = 1'b0, cgra = 1'b0;
  logic       ready = 1'b0, done = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ifb ();

  assign ifa.id_rs1_i = rs1;            assign ifb.id_rs1_i = rs1;
  assign ifa.id_rs2_i = rs2;            assign ifb.id_rs2_i = rs2;
  assign ifa.id_uses_rs2_i = uses2;     assign ifb.id_uses_rs2_i = uses2;
  assign ifa.ex_memread_i = memread;    assign ifb.ex_memread_i = memread;
  assign ifa.ex_rd_i = rd;              assign ifb.ex_rd_i = rd;
  assign ifa.ex_branch_taken_i = br;    assign ifb.ex_branch_taken_i = br;
  assign ifa.ex_cgra_op_i = cgra;       assign ifb.ex_cgra_op_i = cgra;
  assign ifa.cgra_ready_i = ready;      assign ifb.cgra_ready_i = ready;
  assign ifa.cgra_done_i = done;        assign ifb.cgra_done_i = done;

  pipe_hazard_ctrl #(.CGRA_TIMEOUT(256), .TO_W(9), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  pipe_hazard_ctrl #(.CGRA_TIMEOUT(8), .TO_W(4), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave));

  // Model: an outstanding CGRA job (accepted or not, age in cycles) or a release cycle.
  bit m_act[2], m_acc[2], m_rel[2], m_err[2];
  int m_age[2], m_stall[2];
  int t_lim[2] = '{256, 8};

  // Vector order: pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, cgra_start, busy, err
  function automatic logic [7:0] exp_vec(int k);
    logic lu;
    lu = memread && (rd != 5'd0) && ((rd == rs1) || (uses2 && (rd == rs2)));
    if (rst)       return {2'b11, 5'b00000, m_err[k]};
    if (m_rel[k])  return {2'b11, 4'b0000, 1'b1, m_err[k]};
    if (m_act[k])  return {2'b00, 2'b00, 1'b1, ~m_acc[k], 1'b1, m_err[k]};
    if (cgra)      return {2'b00, 2'b00, 1'b1, 1'b0, 1'b0, m_err[k]};
    if (br)        return {2'b11, 2'b11, 3'b000, m_err[k]};
    if (lu)        return {2'b00, 1'b0, 1'b1, 3'b000, m_err[k]};
    return {2'b11, 5'b00000, m_err[k]};
  endfunction

  function automatic logic [15:0] exp_stall(int k);
`ifdef HAZARD_PERF_CNT_EN
    return 16'(m_stall[k]);
`else
    return (k < 0) ? 16'(m_stall[0]) : 16'd0;
`endif
  endfunction

  function automatic logic [7:0] obs_vec(int k);
    if (k == 0)
      return {ifa.pc_write_o, ifa.ifid_write_o, ifa.ifid_flush_o, ifa.idex_flush_o,
              ifa.idex_hold_o, ifa.cgra_start_o, ifa.busy_o, ifa.err_o};
    return {ifb.pc_write_o, ifb.ifid_write_o, ifb.ifid_flush_o, ifb.idex_flush_o,
            ifb.idex_hold_o, ifb.cgra_start_o, ifb.busy_o, ifb.err_o};
  endfunction

  function automatic logic [15:0] obs_stall(int k);
    return (k == 0) ? ifa.stall_cnt_o : ifb.stall_cnt_o;
  endfunction

  // Advance one clock edge and move the model along with the inputs of the ending cycle.
  task automatic tick();
    logic [7:0] e [2];
    for (int k = 0; k < 2; k++) e[k] = exp_vec(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 0; m_acc[k] = 0; m_rel[k] = 0; m_err[k] = 0; m_age[k] = 0; m_stall[k] = 0;
      end else begin
        if (!e[k][7] && m_stall[k] < 65535) m_stall[k]++;
        if (m_rel[k]) begin
          m_rel[k] = 0;
        end else if (m_act[k]) begin
          if (m_acc[k] && done) begin
            m_act[k] = 0; m_rel[k] = 1;
          end else if (m_age[k] == t_lim[k] - 1) begin
            m_err[k] = 1; m_act[k] = 0; m_rel[k] = 1;
          end else begin
            m_age[k]++;
            if (ready) m_acc[k] = 1;
          end
        end else if (cgra) begin
          m_act[k] = 1; m_acc[k] = 0; m_age[k] = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; uses2 = 0; memread = 0; br = 0; cgra = 0; ready = 0; done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_vec(k) !== 8'b1100_0000 || obs_stall(k) !== 16'd0) begin
        $display("FAIL reset_state dut%0d got=%b/%0d want=11000000/0", k, obs_vec(k), obs_stall(k));
        bad++;
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin memread = 1; rd = 5'd5; rs1 = 5'd5; end
      if (c == 2) begin memread = 1; rd = 5'd0; rs1 = 5'd0; end
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL load_use c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      if (c == 0) begin
        total++;
        if ({ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_flush_o} !== 3'b001) begin
          $display("FAIL load_use_stall got=%b want=001", {ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_flush_o});
          bad++;
        end
      end
      tick();
    end
  endtask

  task automatic test_rs2_gating();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      memread = 1; rd = 5'd7; rs2 = 5'd7; rs1 = 5'd3; uses2 = (c == 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL rs2_gating c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      tick();
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    idle_inputs();
    br = 1; memread = 1; rd = 5'd9; rs1 = 5'd9;
    #1;
    total++;
    if ({ifa.ifid_flush_o, ifa.idex_flush_o, ifa.pc_write_o} !== 3'b111) begin
      $display("FAIL branch_over_load got=%b want=111", {ifa.ifid_flush_o, ifa.idex_flush_o, ifa.pc_write_o});
      bad++;
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_vec(k) !== exp_vec(k)) begin
        $display("FAIL branch_model dut%0d got=%b want=%b", k, obs_vec(k), exp_vec(k));
        bad++;
      end
    end
    tick();
  endtask

  task automatic test_cgra_handshake();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
      cgra = (c <= 11); ready = (c == 3); done = (c == 10);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL handshake c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      total++;
      if (ifa.cgra_start_o !== (c >= 1 && c <= 3) || ifa.idex_hold_o !== (c <= 10) ||
          ifa.busy_o !== (c >= 1 && c <= 11) || ifa.err_o !== 1'b0) begin
        $display("FAIL handshake_seq c=%0d got start=%b hold=%b busy=%b err=%b", c,
                 ifa.cgra_start_o, ifa.idex_hold_o, ifa.busy_o, ifa.err_o);
        bad++;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (c == 12) begin
        total++;
        if (ifa.stall_cnt_o !== 16'd11) begin
          $display("FAIL handshake_stalls got=%0d want=11", ifa.stall_cnt_o);
          bad++;
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      cgra = (c <= 9); ready = (c == 2);
      if (c == 14) rst = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL timeout c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      total++;
      if (ifb.err_o !== (c >= 9 && c <= 14) || ifb.busy_o !== (c >= 1 && c <= 9) ||
          (c == 9 && ifb.pc_write_o !== 1'b1)) begin
        $display("FAIL timeout_seq c=%0d got err=%b busy=%b pc=%b", c, ifb.err_o, ifb.busy_o, ifb.pc_write_o);
        bad++;
      end
      tick();
      rst = 0;
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      cgra = 1; ready = (c == 1); rst = (c == 4);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL reset_wait c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      if (c == 4) begin
        total++;
        if ({ifa.pc_write_o, ifa.cgra_start_o, ifa.busy_o, ifa.idex_hold_o} !== 4'b1000) begin
          $display("FAIL reset_wait_forced got=%b want=1000",
                   {ifa.pc_write_o, ifa.cgra_start_o, ifa.busy_o, ifa.idex_hold_o});
          bad++;
        end
      end
      tick();
      rst = 0;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      cgra    = ($urandom_range(0, 9) == 0);
      ready   = ($urandom_range(0, 2) == 0);
      done    = ($urandom_range(0, 5) == 0);
      br      = ($urandom_range(0, 5) == 0);
      memread = $urandom_range(0, 1) == 1;
      uses2   = $urandom_range(0, 1) == 1;
      rd      = 5'($urandom_range(0, 3));
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k) || obs_stall(k) !== exp_stall(k)) begin
          $display("FAIL random c=%0d dut%0d got=%b/%0d want=%b/%0d", c, k, obs_vec(k), obs_stall(k), exp_vec(k), exp_stall(k));
          bad++;
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_rs2_gating();
    test_branch_priority();
    test_cgra_handshake();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
